// File: rtl/conv_result_collector_pkg.sv
// rtl/conv_result_collector_pkg.sv - shared geometry helpers and FSM state encoding for the result collector
package conv_result_collector_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  function automatic int out_dim(input int n, input int k);
    return n - k + 1;
  endfunction

  function automatic int frame_depth(input int n, input int k);
    return out_dim(n, k) * out_dim(n, k);
  endfunction

endpackage

// File: rtl/conv_result_collector_if.sv
// rtl/conv_result_collector_if.sv - valid/ready drain stream leaving the result collector
interface conv_result_collector_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_last_o;

  modport master (
    output m_valid_o,
    output m_data_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o,
    input  m_data_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/conv_result_collector_result_buf.sv
// rtl/conv_result_collector_result_buf.sv - frame register array, one write port, one combinational read port
module conv_result_collector_result_buf #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Contents are deliberately left unreset; the FSM never reads an unwritten entry.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_result_collector.sv
// rtl/conv_result_collector.sv - capture conv results into a frame buffer and drain them in raster order
module conv_result_collector
  import conv_result_collector_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int K_SIZE     = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  running_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  conv_result_collector_if.master m,
  output logic                  frame_done_o,
  output logic                  short_o,
  output logic                  overflow_o,
  output logic [CNT_W-1:0]      wr_count_o
);

  localparam int OUT_DIM = out_dim(N, K_SIZE);
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             short_q, short_d;
  logic             overflow_q, overflow_d;

  logic                  wr_en;
  logic                  out_valid;
  logic                  out_last;
  logic                  beat;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    out_valid = (state_q == ST_DRAIN) && (rd_ptr_q < wr_count_q);
    out_last  = out_valid && (rd_ptr_q == wr_count_q - ONE_C);
    beat      = out_valid && m.m_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    rd_ptr_d   = rd_ptr_q;
    short_d    = short_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;

    // start_i wins over everything, and a sample arriving with it is silently dropped.
    if (start_i) begin
      state_d    = ST_ARMED;
      wr_count_d = '0;
      rd_ptr_d   = '0;
      short_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (valid_i) begin
        if (((state_q == ST_ARMED) || (state_q == ST_CAPTURE)) && (wr_count_q < DEPTH_C)) begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_q + ONE_C;
        end else begin
          overflow_d = 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          if (wr_count_d == DEPTH_C) begin
            state_d = ST_DRAIN;
          end else if (running_i) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (wr_count_d == DEPTH_C) begin
            state_d = ST_DRAIN;
          end else if (!running_i) begin
            short_d = 1'b1;
            state_d = (wr_count_d != '0) ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (beat) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            if (out_last) begin
              rd_ptr_d = '0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      rd_ptr_q   <= '0;
      short_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_ptr_q   <= rd_ptr_d;
      short_q    <= short_d;
      overflow_q <= overflow_d;
    end
  end

  conv_result_collector_result_buf #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_result_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_count_q[AW-1:0]),
    .wdata (data_i),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign m.m_valid_o   = out_valid;
  assign m.m_last_o    = out_last;
  assign m.m_data_o    = out_valid ? rd_data : '0;
  assign frame_done_o  = beat && out_last;
  assign short_o       = short_q;
  assign overflow_o    = overflow_q;
  assign wr_count_o    = wr_count_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// tb/tb_conv_result_collector.sv - self-checking bench for conv_result_collector (N=4, K_SIZE=3, DEPTH=4)
module tb_conv_result_collector;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        running_i;
  logic        valid_i;
  logic [15:0] data_i;
  logic        frame_done_o;
  logic        short_o;
  logic        overflow_o;
  logic [15:0] wr_count_o;

  conv_result_collector_if #(.DATA_WIDTH(16)) m_if ();

  conv_result_collector #(
    .N          (4),
    .DATA_WIDTH (16),
    .K_SIZE     (3),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .running_i    (running_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .m            (m_if),
    .frame_done_o (frame_done_o),
    .short_o      (short_o),
    .overflow_o   (overflow_o),
    .wr_count_o   (wr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        o_valid, o_last, o_done, o_short, o_ovf;
  logic [15:0] o_data, o_wc;

  typedef enum int {P_IDLE, P_ARMED, P_CAP, P_DRAIN} phase_t;
  phase_t      ph;
  logic [15:0] cap[$];
  int          sent;
  bit          m_short, m_ovf;

  logic [15:0] exp_q[$];

  typedef struct packed {
    bit          st, run, vld;
    logic [15:0] dat;
    bit          rdy;
    bit          ev, el, edn, es, eo;
    logic [15:0] edata;
    logic [15:0] ewc;
  } vec_t;
  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] pack(input bit v, input bit l, input bit d, input bit s, input bit o,
                                       input logic [15:0] dat, input logic [15:0] wc);
    return {v, l, d, s, o, (v ? dat : 16'h0), wc};
  endfunction

  task automatic m_reset();
    ph = P_IDLE;
    cap.delete();
    sent = 0;
    m_short = 0;
    m_ovf = 0;
  endtask

  // Frame-level reference: captured samples live in a queue, drained by index.
  task automatic model_step(input bit st, input bit run, input bit vld, input logic [15:0] dat,
                            input bit acc, input bit last);
    if (st) begin
      ph = P_ARMED;
      cap.delete();
      sent = 0;
      m_short = 0;
      m_ovf = 0;
    end else begin
      if (vld) begin
        if ((ph == P_ARMED || ph == P_CAP) && cap.size() < DEPTH) cap.push_back(dat);
        else m_ovf = 1;
      end
      case (ph)
        P_ARMED: if (cap.size() == DEPTH) ph = P_DRAIN; else if (run) ph = P_CAP;
        P_CAP: begin
          if (cap.size() == DEPTH) ph = P_DRAIN;
          else if (!run) begin
            m_short = 1;
            ph = (cap.size() > 0) ? P_DRAIN : P_IDLE;
          end
        end
        P_DRAIN: if (acc) begin
          sent++;
          if (last) begin
            ph = P_IDLE;
            sent = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit st, input bit run, input bit vld, input logic [15:0] dat, input bit rdy);
    bit ev, el;
    logic [15:0] ed;
    @(negedge clk);
    start_i = st; running_i = run; valid_i = vld; data_i = dat; m_if.m_ready_i = rdy;
    #1;
    o_valid = m_if.m_valid_o; o_last = m_if.m_last_o; o_data = m_if.m_data_o;
    o_done = frame_done_o; o_short = short_o; o_ovf = overflow_o; o_wc = wr_count_o;
    ev = (ph == P_DRAIN) && (sent < cap.size());
    ed = ev ? cap[sent] : 16'h0;
    el = ev && (sent == cap.size() - 1);
    chk("model", pack(o_valid, o_last, o_done, o_short, o_ovf, o_data, o_wc),
        pack(ev, el, ev && rdy && el, m_short, m_ovf, ed, 16'(cap.size())));
    model_step(st, run, vld, dat, rdy && ev, el);
  endtask

  // pat 0: always ready; pat 1: ready pattern 1,0,0 repeating.
  task automatic drain(input int pat, input int limit);
    int beats, dones, done_at;
    bit rdy;
    beats = 0; dones = 0; done_at = -1;
    for (int c = 0; c < limit && dones == 0; c++) begin
      rdy = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      cycle(0, 0, 0, 16'h0, rdy);
      if (o_valid) begin
        if (beats < exp_q.size())
          chk("drain_beat", {o_data, o_last}, {exp_q[beats], (beats == exp_q.size() - 1)});
        else
          chk("extra_beat", o_valid, 1'b0);
      end
      if (o_valid && rdy) beats++;
      if (o_done) begin
        dones++;
        done_at = beats;
      end
    end
    chk("beat_count", beats, exp_q.size());
    chk("done_count", dones, 1);
    chk("done_on_last", done_at, exp_q.size());
  endtask

  task automatic feed_frame(input bit gaps);
    cycle(1, 0, 0, 16'h0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      cycle(0, 1, 1, exp_q[i], 0);
      if (gaps && i != exp_q.size() - 1) cycle(0, 1, 0, 16'h0, 0);
    end
  endtask

  initial begin
    rst = 1'b0; start_i = 0; running_i = 0; valid_i = 0; data_i = '0; m_if.m_ready_i = 0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_state", {m_if.m_valid_o, m_if.m_last_o, frame_done_o, short_o, overflow_o, wr_count_o}, '0);
    @(negedge clk);
    rst = 1'b1;

    vt[0]  = '{1, 0, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd0};
    vt[1]  = '{0, 1, 1, 16'h0011, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd0};
    vt[2]  = '{0, 1, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd1};
    vt[3]  = '{0, 1, 1, 16'h0022, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd1};
    vt[4]  = '{0, 1, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd2};
    vt[5]  = '{0, 1, 1, 16'h0033, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd2};
    vt[6]  = '{0, 1, 0, 16'h0000, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd3};
    vt[7]  = '{0, 1, 1, 16'h0044, 0,  0, 0, 0, 0, 0, 16'h0000, 16'd3};
    vt[8]  = '{0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 0, 16'h0011, 16'd4};
    vt[9]  = '{0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 0, 16'h0022, 16'd4};
    vt[10] = '{0, 0, 0, 16'h0000, 1,  1, 0, 0, 0, 0, 16'h0033, 16'd4};
    vt[11] = '{0, 0, 0, 16'h0000, 1,  1, 1, 1, 0, 0, 16'h0044, 16'd4};
    vt[12] = '{0, 0, 1, 16'h0F0F, 1,  0, 0, 0, 0, 0, 16'h0000, 16'd4};
    vt[13] = '{0, 0, 0, 16'h0000, 0,  0, 0, 0, 0, 1, 16'h0000, 16'd4};

    for (int i = 0; i < 14; i++) begin
      cycle(vt[i].st, vt[i].run, vt[i].vld, vt[i].dat, vt[i].rdy);
      chk($sformatf("vec%0d", i), pack(o_valid, o_last, o_done, o_short, o_ovf, o_data, o_wc),
          pack(vt[i].ev, vt[i].el, vt[i].edn, vt[i].es, vt[i].eo, vt[i].edata, vt[i].ewc));
    end

    // Backpressured drain: data/last must hold while stalled.
    exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    feed_frame(1);
    drain(1, 40);
    chk("stall_short", o_short, 1'b0);
    chk("stall_ovf", o_ovf, 1'b0);

    // Short frame: running_i drops after two samples.
    exp_q = '{16'h00AA, 16'h00BB};
    feed_frame(0);
    cycle(0, 0, 0, 16'h0, 0);
    drain(0, 10);
    chk("short_flag", o_short, 1'b1);

    // Stray sample during DRAIN is dropped and flagged.
    exp_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    feed_frame(0);
    cycle(0, 0, 1, 16'h0F0F, 0);
    cycle(0, 0, 0, 16'h0, 0);
    chk("drain_ovf", {o_ovf, o_valid, o_data, o_wc}, {1'b1, 1'b1, 16'h0101, 16'd4});
    drain(0, 10);

    // Abort mid-drain with start_i, then a fresh frame.
    exp_q = '{16'h0055, 16'h0066, 16'h0077, 16'h0088};
    feed_frame(0);
    cycle(0, 0, 1, 16'h0F0F, 1);
    cycle(0, 0, 0, 16'h0, 1);
    chk("pre_abort", {o_ovf, o_data}, {1'b1, 16'h0066});
    cycle(1, 0, 0, 16'h0, 0);
    cycle(0, 1, 1, 16'h0001, 0);
    chk("abort_clear", {o_valid, o_short, o_ovf, o_wc}, {1'b0, 1'b0, 1'b0, 16'd0});
    cycle(0, 1, 1, 16'h0002, 0);
    cycle(0, 1, 1, 16'h0003, 0);
    cycle(0, 1, 1, 16'h0004, 0);
    exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    drain(0, 10);

    // Asynchronous reset in the middle of CAPTURE.
    cycle(1, 0, 0, 16'h0, 0);
    cycle(0, 1, 1, 16'h0055, 1);
    cycle(0, 1, 1, 16'h0066, 1);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset", {m_if.m_valid_o, m_if.m_last_o, frame_done_o, short_o, overflow_o, wr_count_o}, '0);
    m_reset();
    start_i = 0; valid_i = 0; running_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1'($urandom_range(0, 1)), 16'($urandom), 1);
      chk("idle_after_reset", o_valid, 1'b0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
Sink-side companion to the image-fetch/convolution top. It accepts the convolution result stream (data/valid) and packs the valid results into an internal (N-K_SIZE+1)^2 frame buffer. Once the frame is complete, it drains the buffer in raster order over a valid/ready stream toward downstream logic (UART/DMA/compare). It also reports completion, short-frame and overflow status.

Parameters:
N, 4, input image side length (pixels)
DATA_WIDTH, 16, result sample width (Q-format passthrough, no arithmetic)
K_SIZE, 3, kernel side length; OUT_DIM = N-K_SIZE+1 (localparam), DEPTH = OUT_DIM*OUT_DIM
CNT_W, 16, width of count/address registers; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start_i  input  1  one-cycle pulse: arm a new capture; clears counters and sticky flags
running_i  input  1  upstream frame-active indication (fetch in progress)
valid_i  input  1  result sample valid this cycle
data_i  input  DATA_WIDTH  result sample
m_valid_o  output  1  drain stream valid
m_ready_i  input  1  drain stream ready
m_data_o  output  DATA_WIDTH  drained sample
m_last_o  output  1  high with the final drained sample (index DEPTH-1)
frame_done_o  output  1  one-cycle pulse on the last accepted drain beat
short_o  output  1  sticky: running_i fell before DEPTH samples were captured
overflow_o  output  1  sticky: valid_i seen while the buffer was full or outside CAPTURE
wr_count_o  output  CNT_W  samples captured in the current frame

Behaviour:
- Reset (rst low, async): state IDLE; m_valid_o=0, m_last_o=0, frame_done_o=0, short_o=0, overflow_o=0, wr_count_o=0, rd_ptr=0. Buffer contents are not reset.
- States: IDLE, ARMED, CAPTURE, DRAIN.
- IDLE: start_i -> ARMED. valid_i here sets overflow_o and the sample is dropped.
- ARMED: waits for running_i=1, then -> CAPTURE. valid_i while ARMED is captured, because upstream may assert valid on its first running cycle.
- CAPTURE: each valid_i writes data_i to mem[wr_count] and increments wr_count.
  - When the write with wr_count==DEPTH-1 is accepted -> DRAIN next cycle.
  - valid_i while wr_count==DEPTH in the same cycle is impossible by construction; any valid_i in DRAIN sets overflow_o and is dropped.
  - running_i falling while wr_count<DEPTH: set short_o. If wr_count>0 -> DRAIN (drain only captured entries, m_last_o on index wr_count-1). If wr_count==0 -> IDLE.
- DRAIN: m_valid_o=1 whenever rd_ptr<wr_count. m_data_o=mem[rd_ptr] (combinational read from register array; zero-latency beat).
  - Beat accepted when m_valid_o&&m_ready_i; rd_ptr increments on each accepted beat.
  - On the accepted last beat: frame_done_o pulses for 1 cycle, next state IDLE, rd_ptr cleared.
  - m_data_o/m_last_o stay stable while m_valid_o=1 and m_ready_i=0.
- start_i priority: start_i in any state (including mid-CAPTURE or mid-DRAIN) aborts the current frame and goes to ARMED. It clears wr_count, rd_ptr, short_o, overflow_o and m_valid_o the next cycle. A valid_i in the same cycle as start_i is discarded without setting overflow_o.
- Latency: last capture write -> m_valid_o high 1 cycle later; first beat is accepted that same cycle if m_ready_i=1. Full drain takes DEPTH cycles minimum.
- Widths: all counters are CNT_W bits and never wrap within a frame. Data is stored and replayed bit-exact.

Decomposition:
- Shared package/header: OUT_DIM/DEPTH derivation helpers, state encoding constants (IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3). These are reused by the fetch top and future writers.
- One natural sub-module: result_buf (DEPTH x DATA_WIDTH register array, one write port, one async read port). Control FSM stays in conv_result_collector.

Test Plan:
- Config N=4, K_SIZE=3 (DEPTH=4): start_i, running_i=1, valid_i with 0x0011,0x0022,0x0033,0x0044 on non-consecutive cycles, m_ready_i=1 -> 4 beats in order, m_last_o on 0x0044, frame_done_o one pulse, short_o=0, overflow_o=0.
- Same frame with m_ready_i toggling 1,0,0,1,... -> data/last held stable while stalled; exactly 4 accepted beats; frame_done_o only on the 4th.
- running_i drops after 2 samples (0x00AA,0x00BB) -> short_o=1, drain of 2 beats, m_last_o on 0x00BB, frame_done_o pulse.
- Extra valid_i (0x0F0F) during DRAIN and valid_i while IDLE -> overflow_o=1, drained data unchanged, wr_count_o stays 4.
- start_i asserted after 2 drained beats -> next cycle m_valid_o=0, flags cleared, wr_count_o=0, state ARMED; a fresh frame 0x1,0x2,0x3,0x4 drains correctly.
- rst low mid-CAPTURE (asynchronous, not clock-aligned) -> all outputs 0 immediately; after release, no m_valid_o until start_i.
